// File: rtl/alu_pkg.sv
// alu_pkg: sel op codes and FSM state encoding shared by alu_seq and the ALU control decoder
package alu_pkg;
  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;
  localparam logic [3:0] SEL_MUL = 4'd2;
  localparam logic [3:0] SEL_DIV = 4'd3;
  localparam logic [3:0] SEL_AND = 4'd4;
  localparam logic [3:0] SEL_OR  = 4'd5;
  localparam logic [3:0] SEL_XOR = 4'd6;
  localparam logic [3:0] SEL_NOT = 4'd7;
  localparam logic [3:0] SEL_SLT = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: W-step shift-add multiply / restoring divide; ports clk, rst_n, start_mul, start_div, a, b in; fin (final-step pulse) and y (low product or quotient, valid with fin) out
module seq_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_mul,
  input  logic         start_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         fin,
  output logic [W-1:0] y
);
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] cnt_q;
  logic run_q, mul_q, ge;
  logic [W-1:0] acc_q, sh_q, mc_q, acc_d, sh_d;
  logic [W:0] rem;
  always_comb begin
    rem = {acc_q, sh_q[W-1]};
    ge = rem >= {1'b0, mc_q};
    acc_d = mul_q ? acc_q + (sh_q[0] ? mc_q : '0) : ge ? W'(rem - {1'b0, mc_q}) : rem[W-1:0];
    sh_d = mul_q ? sh_q >> 1 : {sh_q[W-2:0], ge};
  end
  assign fin = run_q && cnt_q == CW'(1);
  assign y = mul_q ? acc_d : sh_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      mul_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      sh_q  <= '0;
      mc_q  <= '0;
    end else if (start_mul || start_div) begin
      run_q <= 1'b1;
      mul_q <= start_mul;
      cnt_q <= CW'(W);
      acc_q <= '0;
      sh_q  <= start_mul ? b : a;
      mc_q  <= start_mul ? a : b;
    end else if (run_q) begin
      run_q <= !fin;
      cnt_q <= cnt_q - CW'(1);
      acc_q <= acc_d;
      sh_q  <= sh_d;
      mc_q  <= mul_q ? mc_q << 1 : mc_q;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU; ports clk, rst_n, start, sel, a, b in; result, zero, div_by_zero, busy, done out
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         div_by_zero,
  output logic         busy,
  output logic         done
);
  state_e state_q;
  logic [W-1:0] result_q, op_d, md_y;
  logic zero_q, dbz_q, accept, start_mul, start_div, md_fin;
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
  assign start_mul = accept && sel == SEL_MUL;
  assign start_div = accept && sel == SEL_DIV && b != '0;
  always_comb begin
    op_d = sel == SEL_ADD ? a + b
         : sel == SEL_SUB ? a - b
         : sel == SEL_AND ? a & b
         : sel == SEL_OR  ? a | b
         : sel == SEL_XOR ? a ^ b
         : sel == SEL_NOT ? ~a
         : sel == SEL_SLT ? {{(W-1){1'b0}}, $signed(a) < $signed(b)}
         : sel == SEL_DIV ? '1
         : '0;
  end
  seq_muldiv #(.W(W)) u_md (
    .clk(clk), .rst_n(rst_n), .start_mul(start_mul), .start_div(start_div),
    .a(a), .b(b), .fin(md_fin), .y(md_y)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else if (state_q == S_MUL || state_q == S_DIV) begin
      if (md_fin) begin
        state_q  <= S_DONE;
        result_q <= md_y;
        zero_q   <= md_y == '0;
        dbz_q    <= 1'b0;
      end
    end else if (start_mul) begin
      state_q <= S_MUL;
    end else if (start_div) begin
      state_q <= S_DIV;
    end else if (accept) begin
      state_q  <= S_DONE;
      result_q <= op_d;
      zero_q   <= op_d == '0;
      dbz_q    <= sel == SEL_DIV;
    end else begin
      state_q <= S_IDLE;
    end
  end
  assign result = result_q;
  assign zero = zero_q;
  assign div_by_zero = dbz_q;
  assign busy = state_q == S_MUL || state_q == S_DIV;
  assign done = state_q == S_DONE;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at W=8 with directed vectors
module tb_alu_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] sel = 0;
  logic [7:0] a = 0, b = 0, result;
  logic zero, div_by_zero, busy, done;
  int checks = 0, errors = 0, cyc = 0, busy_n = 0;
  typedef struct {logic [7:0] r; logic z; logic d; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  alu_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a(a), .b(b),
    .result(result), .zero(zero), .div_by_zero(div_by_zero), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (busy) busy_n++;
    if (busy && done) chk("busy_and_done", 1, 0);
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", int'(result), int'(e.r));
        chk("zero", int'(zero), int'(e.z));
        chk("div_by_zero", int'(div_by_zero), int'(e.d));
        chk("done_cycle", cyc, e.c);
      end
    end
  end
  task automatic wait_idle(input bit multi);
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() > 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    chk("busy_cycles", busy_n, multi ? 8 : 0);
  endtask
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                       input logic [7:0] er, input logic ed, input bit multi, input bit wt);
    @(negedge clk);
    a = ta; b = tb; sel = ts; start = 1;
    busy_n = 0;
    @(posedge clk);
    #1;
    start = 0;
    q.push_back('{er, er == 8'd0, ed, cyc + (multi ? 8 : 0)});
    if (wt) wait_idle(multi);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", int'(result), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_dbz", int'(div_by_zero), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1;
    issue(8'd5, 8'd3, 4'd0, 8'd8, 0, 0, 1);
    issue(8'd3, 8'd3, 4'd1, 8'd0, 0, 0, 1);
    issue(8'd7, 8'd6, 4'd2, 8'd42, 0, 1, 1);
    issue(8'd20, 8'd20, 4'd2, 8'h90, 0, 1, 1);
    issue(8'd100, 8'd7, 4'd3, 8'd14, 0, 1, 1);
    issue(8'd9, 8'd0, 4'd3, 8'hFF, 1, 0, 1);
    issue(8'hFF, 8'd1, 4'd8, 8'd1, 0, 0, 1);
    issue(8'd1, 8'hFF, 4'd8, 8'd0, 0, 0, 1);
    issue(8'd55, 8'd66, 4'd12, 8'd0, 0, 0, 1);
    issue(8'hF0, 8'h3C, 4'd4, 8'h30, 0, 0, 1);
    issue(8'hF0, 8'h3C, 4'd5, 8'hFC, 0, 0, 1);
    issue(8'hF0, 8'h3C, 4'd6, 8'hCC, 0, 0, 1);
    issue(8'h0F, 8'hAA, 4'd7, 8'hF0, 0, 0, 1);
    issue(8'd255, 8'd1, 4'd3, 8'd255, 0, 1, 1);
    issue(8'd255, 8'd255, 4'd2, 8'h01, 0, 1, 1);
    issue(8'd1, 8'd1, 4'd0, 8'd2, 0, 0, 0);
    issue(8'h12, 8'h34, 4'd6, 8'h26, 0, 0, 0);
    issue(8'd0, 8'd1, 4'd1, 8'hFF, 0, 0, 1);
    issue(8'd7, 8'd6, 4'd2, 8'd42, 0, 1, 0);
    repeat (3) @(negedge clk);
    a = 1; b = 1; sel = 0; start = 1;
    @(negedge clk);
    start = 0;
    wait_idle(1);
    repeat (5) @(negedge clk);
    issue(8'd7, 8'd6, 4'd2, 8'd42, 0, 1, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_zero", int'(zero), 1);
    chk("mid_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle execution unit that consumes the 4-bit `sel` code produced by the ALU control decoder and performs the selected operation on two operands. Single-cycle logic and add/sub/slt operations complete in one cycle. Multiply and divide run iteratively. A start/busy/done handshake lets the multi-cycle control FSM stall the datapath until a result is ready.

## Interface
Parameters:
- `W`, default 32: operand and result width; must be at least 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when not busy.
- `sel`  in  4  operation code: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not, 8 slt; 9–15 are illegal.
- `a`  in  W  operand A; captured on an accepted start.
- `b`  in  W  operand B; captured on an accepted start.
- `result`  out  W  registered result; holds until the next completion.
- `zero`  out  1  registered; 1 when `result` == 0.
- `div_by_zero`  out  1  registered; set on completion of a div with b==0, cleared on any other completion.
- `busy`  out  1  high while in state MUL or DIV.
- `done`  out  1  one-cycle pulse when `result` updates.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept rule: start is accepted when `start`=1 and state is IDLE or DONE.
- Start is ignored in MUL and DIV. No queuing.
- On accept, latch `a`, `b`, `sel`, then:
  - sel 2 → MUL.
  - sel 3 with b≠0 → DIV.
  - Everything else, including div-by-zero and illegal sel → DONE.
- DONE with no new start → IDLE.
- Single-cycle results, written on the transition into DONE:
  - Add/sub: modulo 2^W, no carry or overflow outputs.
  - and/or/xor: bitwise.
  - not: ~a; b is ignored.
  - slt: signed compare, result = 1 if a<b else 0, zero-extended.
  - Illegal sel: result 0.
- Mul:
  - Unsigned shift-add over exactly W iterations, one bit of b per cycle, LSB first.
  - Result = low W bits of the product.
- Div:
  - Unsigned restoring division over exactly W iterations.
  - Result = quotient; the remainder is discarded.
- Div by zero:
  - No iteration.
  - Result = all ones, `div_by_zero`=1.
- Reset, asynchronous, any state:
  - State → IDLE.
  - `result`=0, `zero`=1, `div_by_zero`=0, `busy`=0, `done`=0.
  - Internal accumulators and counters are cleared.
  - Any in-flight mul/div is abandoned and no `done` is produced.

## Timing
- Accept at edge N:
  - Single-cycle ops, div-by-zero and illegal sel: `done`=1 and `result` valid in cycle N+1.
  - Mul and div: `busy`=1 in cycles N+1 … N+W, then `done`=1 and `result` valid in cycle N+W+1.
- `zero` and `div_by_zero` update in the same cycle as `done`.
- Back-to-back issue: a start accepted during a DONE cycle gives a new `done` one cycle later for single-cycle ops. Sustained throughput is 1 op/cycle.
- Operands may change freely after the accept edge, because latched copies are used.
- `busy` and `done` are never high together.

## Structure
- Shared package `alu_pkg` holds:
  - `sel` localparams: SEL_ADD=0 … SEL_SLT=8.
  - The state encoding for IDLE, MUL, DIV, DONE.
  - These constants are shared with the ALU control decoder, which produces `sel`.
- Sub-module `seq_muldiv` is natural for the iterative engine:
  - Inputs: `start_mul`, `start_div`, operands.
  - Contents: W-iteration counter, shared accumulator and shift register.
  - Outputs: a `fin` pulse and a W-bit output.
- `alu_seq` owns the FSM, the single-cycle logic and the output registers.

## Test plan
All cases use W=8.
- Add: a=5, b=3, sel=0, start at N → `done` at N+1, result=8, zero=0; then sub 3−3 → result=0, zero=1.
- Mul: a=7, b=6, sel=2 → `busy` for 8 cycles, `done` at N+9, result=42; also 20×20 → result=0x90, the low bits of 400.
- Div: a=100, b=7, sel=3 → `done` at N+9, result=14, div_by_zero=0.
- Div by zero: a=9, b=0, sel=3 → `done` at N+1, result=0xFF, div_by_zero=1.
- Slt and illegal sel: slt a=0xFF (−1), b=1 → result=1; slt a=1, b=0xFF → result=0; sel=12 → result=0 at N+1.
- Control edges:
  - A start pulsed mid-mul is ignored: exactly one `done`.
  - `rst_n` low at N+4 of a mul → immediately busy=0 and result=0; no `done` after reset is released.
